// File: rtl/ball_layer_compositor_if.sv
// Pixel-side bundle between the sprite bitmaps / pixel counters and the layer compositor.
interface ball_layer_compositor_if #(
  parameter int unsigned NUM_LAYERS = 4
) ();
  logic                    startOfFrame;
  logic [10:0]             pixelX;
  logic [10:0]             pixelY;
  logic [NUM_LAYERS-1:0]   layerDR;
  logic [8*NUM_LAYERS-1:0] layerRGB;
  logic [7:0]              backgroundRGB;
  logic [7:0]              RGBOut;
  logic                    frameValid;
  logic                    ropeHitBall;
  logic                    ballHitPlayer;
  logic [7:0]              hitCount;
  logic [10:0]             hitX;
  logic [10:0]             hitY;

  modport master (
    output startOfFrame, pixelX, pixelY, layerDR, layerRGB, backgroundRGB,
    input  RGBOut, frameValid, ropeHitBall, ballHitPlayer, hitCount, hitX, hitY
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, layerDR, layerRGB, backgroundRGB,
    output RGBOut, frameValid, ropeHitBall, ballHitPlayer, hitCount, hitX, hitY
  );
endinterface

// File: rtl/ball_layer_compositor.sv
// Priority compositor for sprite layers plus per-frame rope/ball/player overlap reporting.
// Define BALL_COMPOSITOR_HIT_COORD_EN to capture the first-overlap coordinate on hitX/hitY.
module ball_layer_compositor #(
  parameter int unsigned NUM_LAYERS           = 4,
  parameter int unsigned BALL_LAYER           = 1,
  parameter int unsigned ROPE_LAYER           = 0,
  parameter int unsigned PLAYER_LAYER         = 2,
  parameter logic [7:0]  TRANSPARENT_ENCODING = 8'hFF
) (
  input logic                     clk,
  input logic                     reset,
  ball_layer_compositor_if.slave  bus
);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic [NUM_LAYERS-1:0] eff_dr;
  logic [7:0]            rgb_d, rgb_q;
  logic                  rope_ev, player_ev, any_ev;

  logic       state_d, state_q;
  logic       frame_valid_d, frame_valid_q;
  logic       rope_hit_d, rope_hit_q;
  logic       player_hit_d, player_hit_q;
  logic [7:0] hit_count_d, hit_count_q;
  logic       acc_rope_d, acc_rope_q;
  logic       acc_player_d, acc_player_q;
  logic [7:0] acc_count_d, acc_count_q;

  // A transparent colour counts as "not drawing" for both compositing and overlaps.
  always_comb begin
    eff_dr = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      eff_dr[i] = bus.layerDR[i] && (bus.layerRGB[8*i +: 8] != TRANSPARENT_ENCODING);
    end
  end

  // Walk from the lowest priority upward so the lowest drawing index wins.
  always_comb begin
    rgb_d = bus.backgroundRGB;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (eff_dr[i]) rgb_d = bus.layerRGB[8*i +: 8];
    end
  end

  assign rope_ev   = eff_dr[ROPE_LAYER] & eff_dr[BALL_LAYER];
  assign player_ev = eff_dr[BALL_LAYER] & eff_dr[PLAYER_LAYER];
  assign any_ev    = rope_ev | player_ev;

  always_comb begin
    state_d       = state_q;
    frame_valid_d = 1'b0;
    rope_hit_d    = rope_hit_q;
    player_hit_d  = player_hit_q;
    hit_count_d   = hit_count_q;
    acc_rope_d    = acc_rope_q;
    acc_player_d  = acc_player_q;
    acc_count_d   = acc_count_q;
    if (bus.startOfFrame) begin
      state_d = StRun;
      if (state_q == StRun) begin
        frame_valid_d = 1'b1;
        rope_hit_d    = acc_rope_q;
        player_hit_d  = acc_player_q;
        hit_count_d   = acc_count_q;
      end
      // The startOfFrame pixel already belongs to the new frame.
      acc_rope_d   = rope_ev;
      acc_player_d = player_ev;
      acc_count_d  = any_ev ? 8'd1 : 8'd0;
    end else if (state_q == StRun) begin
      acc_rope_d   = acc_rope_q | rope_ev;
      acc_player_d = acc_player_q | player_ev;
      if (any_ev && (acc_count_q != 8'hFF)) acc_count_d = acc_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q         <= 8'h00;
      state_q       <= StIdle;
      frame_valid_q <= 1'b0;
      rope_hit_q    <= 1'b0;
      player_hit_q  <= 1'b0;
      hit_count_q   <= 8'h00;
      acc_rope_q    <= 1'b0;
      acc_player_q  <= 1'b0;
      acc_count_q   <= 8'h00;
    end else begin
      rgb_q         <= rgb_d;
      state_q       <= state_d;
      frame_valid_q <= frame_valid_d;
      rope_hit_q    <= rope_hit_d;
      player_hit_q  <= player_hit_d;
      hit_count_q   <= hit_count_d;
      acc_rope_q    <= acc_rope_d;
      acc_player_q  <= acc_player_d;
      acc_count_q   <= acc_count_d;
    end
  end

  assign bus.RGBOut        = rgb_q;
  assign bus.frameValid    = frame_valid_q;
  assign bus.ropeHitBall   = rope_hit_q;
  assign bus.ballHitPlayer = player_hit_q;
  assign bus.hitCount      = hit_count_q;

`ifdef BALL_COMPOSITOR_HIT_COORD_EN
  logic        first_seen_d, first_seen_q;
  logic [10:0] first_x_d, first_x_q, first_y_d, first_y_q;
  logic [10:0] hit_x_d, hit_x_q, hit_y_d, hit_y_q;

  // Coordinates stay zero for a frame with no overlap, so publishing needs no extra muxing.
  always_comb begin
    first_seen_d = first_seen_q;
    first_x_d    = first_x_q;
    first_y_d    = first_y_q;
    hit_x_d      = hit_x_q;
    hit_y_d      = hit_y_q;
    if (bus.startOfFrame) begin
      if (state_q == StRun) begin
        hit_x_d = first_x_q;
        hit_y_d = first_y_q;
      end
      first_seen_d = any_ev;
      first_x_d    = any_ev ? bus.pixelX : 11'd0;
      first_y_d    = any_ev ? bus.pixelY : 11'd0;
    end else if ((state_q == StRun) && any_ev && !first_seen_q) begin
      first_seen_d = 1'b1;
      first_x_d    = bus.pixelX;
      first_y_d    = bus.pixelY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_seen_q <= 1'b0;
      first_x_q    <= 11'd0;
      first_y_q    <= 11'd0;
      hit_x_q      <= 11'd0;
      hit_y_q      <= 11'd0;
    end else begin
      first_seen_q <= first_seen_d;
      first_x_q    <= first_x_d;
      first_y_q    <= first_y_d;
      hit_x_q      <= hit_x_d;
      hit_y_q      <= hit_y_d;
    end
  end

  assign bus.hitX = hit_x_q;
  assign bus.hitY = hit_y_q;
`else
  logic unused_coord;
  assign unused_coord = ^{bus.pixelX, bus.pixelY};
  assign bus.hitX     = 11'd0;
  assign bus.hitY     = 11'd0;
`endif

endmodule

// File: doc/ball_layer_compositor.md
# ball_layer_compositor

Consumer end of the sprite bitmap interface: merges the registered `drawingRequest`/`RGBout` pairs from all sprite bitmaps (balls, rope, player) with the background into the single 8-bit pixel driven to the VGA controller. It also detects per-pixel overlaps between designated layers and publishes them once per frame to the game controller, together with a saturating hit count and the optional first-hit coordinate. It sits between the bitmap blocks and the VGA output stage.

## Interface
Parameters:
- NUM_LAYERS, 4, number of sprite layers; index 0 has the highest draw priority
- BALL_LAYER, 1, layer index of the ball sprites
- ROPE_LAYER, 0, layer index of the rope
- PLAYER_LAYER, 2, layer index of the player
- TRANSPARENT_ENCODING, 8'hFF, colour that is never output from a sprite

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse on the first pixel of each frame
- pixelX  in  11  current pixel column, aligned with the layer inputs
- pixelY  in  11  current pixel row, aligned with the layer inputs
- layerDR  in  NUM_LAYERS  per-layer drawing request
- layerRGB  in  8*NUM_LAYERS  per-layer colour; layer i occupies bits [8i+7:8i]
- backgroundRGB  in  8  colour used when no layer draws
- RGBOut  out  8  composited pixel
- frameValid  out  1  one-cycle pulse publishing the previous frame's results
- ropeHitBall  out  1  rope and ball overlapped in the published frame
- ballHitPlayer  out  1  ball and player overlapped in the published frame
- hitCount  out  8  overlapping pixels (either pair) in the published frame, saturating at 255
- hitX  out  11  pixelX of the first overlap in the published frame
- hitY  out  11  pixelY of the first overlap in the published frame

## Operation
- Compositing: RGBOut is the colour of the lowest-index layer with layerDR set. If no layer draws, RGBOut is backgroundRGB.
- A layer with layerDR=1 and colour TRANSPARENT_ENCODING is treated as not drawing, both for compositing and for overlap detection.
- Overlap per pixel: ropeEv = DR[ROPE]&DR[BALL]; playerEv = DR[BALL]&DR[PLAYER].
- Accumulators: accRope and accPlayer are sticky ORs of their events. accCount adds 1 per pixel with ropeEv|playerEv and saturates at 255. firstSeen/firstX/firstY capture pixelX/pixelY on the first event of the frame.
- Frame boundary: on a cycle with startOfFrame=1, the accumulators are copied to the outputs and frameValid pulses. The accumulators are then reloaded with that cycle's pixel only, because the pixel belongs to the new frame.
- Outputs hold their values until the next startOfFrame.
- If no event occurred in a frame, the published values are 0 flags, hitCount=0, and hitX=hitY=0.
- Two states: IDLE (after reset, waiting for the first startOfFrame) and RUN. In IDLE, events are ignored and frameValid never pulses. The first startOfFrame moves the block to RUN, loads the accumulators with that pixel, and does not pulse frameValid.

## Timing
- RGBOut is registered, giving 1 cycle of latency from layerDR/layerRGB/backgroundRGB. Total latency from the bitmap offset inputs is 2 cycles.
- frameValid and the result outputs update on the clock edge that samples startOfFrame=1, so they are visible 1 cycle after the pulse.
- Reset values: RGBOut=8'h00, frameValid=0, ropeHitBall=0, ballHitPlayer=0, hitCount=0, hitX=0, hitY=0. State=IDLE and all accumulators are cleared.
- Reset asserted mid-frame discards the partial frame. After release the block waits in IDLE for a fresh startOfFrame.
- Back-to-back startOfFrame pulses each publish a one-pixel frame.

## Configuration
- BALL_COMPOSITOR_HIT_COORD_EN defined: firstSeen, firstX and firstY are implemented, and hitX/hitY carry the first-overlap coordinate as described above.
- Not defined: the capture logic is removed and hitX/hitY are tied to 0. All other behaviour is identical.

## Test plan
- Layer 0 draws 8'h1C and layer 2 draws 8'hE0 in the same cycle -> RGBOut=8'h1C one cycle later. With all layers off and background=8'h49 -> RGBOut=8'h49.
- Layer 0 has DR=1 with colour 8'hFF, layer 1 draws 8'h9B -> RGBOut=8'h9B, and no rope overlap is counted.
- Frame 1: ball and player overlap for 3 pixels, the first at (100,200). Then startOfFrame -> frameValid pulses once, ballHitPlayer=1, ropeHitBall=0, hitCount=3, hitX=100, hitY=200 (hitX/hitY=0 without the macro).
- 300 rope/ball overlap pixels in one frame, then startOfFrame -> hitCount=255, ropeHitBall=1.
- startOfFrame coincides with an overlap at (0,0); next frame is clean -> first publish excludes that pixel; second publish shows hitCount=1 with hitX=0, hitY=0.
- Reset asserted mid-frame, then released -> all outputs at reset values, and no frameValid until the second startOfFrame after release.
